// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants and state encoding for the instruction fetch unit
package ifu_pkg;

  // Program-counter / memory-address width
  localparam int IFU_PC_W = 8;

  // Instruction width, shared with the instruction register
  localparam int IFU_INSTR_W = 8;

  // Default PC after reset and on start
  localparam int IFU_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_READY = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetches instruction bytes over req/ack and writes them into the IR
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INSTR_W  = IFU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic               IF_clk,
  input  logic               IF_rst_n,
  input  logic               IF_start,
  input  logic               IF_next,
  input  logic               IF_jump,
  input  logic [PC_W-1:0]    IF_jump_addr,
  input  logic               IF_halt,
  output logic               IF_mem_req,
  output logic [PC_W-1:0]    IF_mem_addr,
  input  logic               IF_mem_ack,
  input  logic [INSTR_W-1:0] IF_mem_data,
  output logic [INSTR_W-1:0] IF_ir_data,
  output logic               IF_ir_we,
  output logic [PC_W-1:0]    IF_pc,
  output logic               IF_ir_valid,
  output logic               IF_busy
);

  ifu_state_t      state;
  logic [PC_W-1:0] fetch_addr;
  logic [PC_W-1:0] jump_target;
  // The in-flight byte will be thrown away once the memory acks it
  logic            discard;
  // The discard was caused by a halt, so the ack ends in IDLE rather than a new fetch
  logic            halt_pend;

  // A request's address comes straight from the fetch-address register, so it is
  // stable for as long as the request is held
  assign IF_mem_addr = fetch_addr;

  // Fetch sequencer: PC ownership, memory handshake and IR write strobe
  always_ff @(posedge IF_clk or negedge IF_rst_n) begin
    if (!IF_rst_n) begin
      state       <= ST_IDLE;
      fetch_addr  <= RESET_PC;
      jump_target <= RESET_PC;
      IF_pc       <= RESET_PC;
      IF_ir_data  <= '0;
      IF_ir_we    <= 1'b0;
      IF_ir_valid <= 1'b0;
      IF_mem_req  <= 1'b0;
      IF_busy     <= 1'b0;
      discard     <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      IF_ir_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (IF_start) begin
            state      <= ST_REQ;
            fetch_addr <= RESET_PC;
            IF_mem_req <= 1'b1;
            IF_busy    <= 1'b1;
          end
        end

        ST_REQ: begin
          if (IF_mem_ack) begin
            // The handshake always completes; events seen in the ack cycle
            // itself count the same as events seen while waiting
            discard   <= 1'b0;
            halt_pend <= 1'b0;
            if (halt_pend || IF_halt) begin
              state      <= ST_IDLE;
              IF_mem_req <= 1'b0;
              IF_busy    <= 1'b0;
            end else if (discard || IF_jump) begin
              // Keep the request up and re-issue it at the jump target
              fetch_addr <= IF_jump ? IF_jump_addr : jump_target;
            end else begin
              state      <= ST_LOAD;
              IF_ir_data <= IF_mem_data;
              IF_ir_we   <= 1'b1;
              IF_mem_req <= 1'b0;
            end
          end else if (IF_halt) begin
            halt_pend <= 1'b1;
            discard   <= 1'b1;
          end else if (IF_jump && !halt_pend) begin
            jump_target <= IF_jump_addr;
            discard     <= 1'b1;
          end
        end

        ST_LOAD: begin
          // The IR write is already under way this cycle; it always completes
          IF_pc <= fetch_addr;
          if (IF_halt) begin
            state   <= ST_IDLE;
            IF_busy <= 1'b0;
          end else if (IF_jump) begin
            state      <= ST_REQ;
            fetch_addr <= IF_jump_addr;
            IF_mem_req <= 1'b1;
          end else begin
            state       <= ST_READY;
            IF_ir_valid <= 1'b1;
          end
        end

        ST_READY: begin
          if (IF_halt) begin
            state       <= ST_IDLE;
            IF_ir_valid <= 1'b0;
            IF_busy     <= 1'b0;
          end else if (IF_jump) begin
            state       <= ST_REQ;
            fetch_addr  <= IF_jump_addr;
            IF_mem_req  <= 1'b1;
            IF_ir_valid <= 1'b0;
          end else if (IF_next) begin
            // Wraps modulo 2^PC_W with no flag
            state       <= ST_REQ;
            fetch_addr  <= IF_pc + PC_W'(1);
            IF_mem_req  <= 1'b1;
            IF_ir_valid <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          IF_mem_req <= 1'b0;
          IF_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic       IF_clk;
  logic       IF_rst_n;
  logic       IF_start;
  logic       IF_next;
  logic       IF_jump;
  logic [7:0] IF_jump_addr;
  logic       IF_halt;
  logic       IF_mem_req;
  logic [7:0] IF_mem_addr;
  logic       IF_mem_ack;
  logic [7:0] IF_mem_data;
  logic [7:0] IF_ir_data;
  logic       IF_ir_we;
  logic [7:0] IF_pc;
  logic       IF_ir_valid;
  logic       IF_busy;

  instr_fetch_unit dut (
    .IF_clk      (IF_clk),
    .IF_rst_n    (IF_rst_n),
    .IF_start    (IF_start),
    .IF_next     (IF_next),
    .IF_jump     (IF_jump),
    .IF_jump_addr(IF_jump_addr),
    .IF_halt     (IF_halt),
    .IF_mem_req  (IF_mem_req),
    .IF_mem_addr (IF_mem_addr),
    .IF_mem_ack  (IF_mem_ack),
    .IF_mem_data (IF_mem_data),
    .IF_ir_data  (IF_ir_data),
    .IF_ir_we    (IF_ir_we),
    .IF_pc       (IF_pc),
    .IF_ir_valid (IF_ir_valid),
    .IF_busy     (IF_busy)
  );

  initial IF_clk = 1'b0;
  always #5 IF_clk = ~IF_clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[256];
  int         checks = 0;
  int         errors = 0;
  int         fixed_wait = 0;
  int         last_req_cycles = 0;
  logic [7:0] model_pc = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.addr = a;
    e.data = mem[a];
    exp_q.push_back(e);
  endtask

  task automatic drop_last();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(IF_mem_req), 0);
    check({tag, "_mem_addr"}, 32'(IF_mem_addr), 0);
    check({tag, "_ir_data"}, 32'(IF_ir_data), 0);
    check({tag, "_ir_we"}, 32'(IF_ir_we), 0);
    check({tag, "_pc"}, 32'(IF_pc), 0);
    check({tag, "_ir_valid"}, 32'(IF_ir_valid), 0);
    check({tag, "_busy"}, 32'(IF_busy), 0);
  endtask

  // Memory model: answers each request after a chosen number of wait cycles
  // and checks the address is held while the request is outstanding
  initial begin : memory_model
    logic       in_txn;
    logic [7:0] txn_addr;
    int         wait_left;
    int         req_cycles;
    in_txn      = 1'b0;
    txn_addr    = 8'h00;
    wait_left   = 0;
    req_cycles  = 0;
    IF_mem_ack  = 1'b0;
    IF_mem_data = 8'h00;
    forever begin
      @(negedge IF_clk);
      IF_mem_ack = 1'b0;
      if (!IF_rst_n) begin
        in_txn = 1'b0;
      end else if (IF_mem_req) begin
        if (!in_txn) begin
          in_txn     = 1'b1;
          txn_addr   = IF_mem_addr;
          wait_left  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          req_cycles = 0;
        end else begin
          check("mem_addr_stable", 32'(IF_mem_addr), 32'(txn_addr));
        end
        req_cycles++;
        if (wait_left == 0) begin
          IF_mem_ack      = 1'b1;
          IF_mem_data     = mem[txn_addr];
          in_txn          = 1'b0;
          last_req_cycles = req_cycles;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: every IR write must match the oldest outstanding expectation
  initial begin : ir_monitor
    logic       prev_we;
    logic       pc_pending;
    logic [7:0] pc_exp;
    exp_t       e;
    prev_we    = 1'b0;
    pc_pending = 1'b0;
    pc_exp     = 8'h00;
    forever begin
      @(negedge IF_clk);
      if (pc_pending && IF_rst_n) begin
        check("pc_after_write", 32'(IF_pc), 32'(pc_exp));
        pc_pending = 1'b0;
      end
      if (IF_ir_we) begin
        check("ir_we_single_cycle", 32'(prev_we), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ir_write: got data 0x%0h, expected no write", IF_ir_data);
        end else begin
          e = exp_q.pop_front();
          check("ir_data", 32'(IF_ir_data), 32'(e.data));
          pc_exp     = e.addr;
          pc_pending = 1'b1;
        end
      end
      prev_we = IF_ir_we;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge IF_clk);
      n++;
      if (IF_ir_valid) return;
    end
    check("wait_valid_timeout", 32'(IF_ir_valid), 1);
  endtask

  task automatic wait_we();
    for (int k = 0; k < 60; k++) begin
      @(negedge IF_clk);
      if (IF_ir_we) return;
    end
    check("wait_we_timeout", 32'(IF_ir_we), 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge IF_clk);
      if (!IF_busy) return;
    end
    check("wait_idle_timeout", 32'(IF_busy), 0);
  endtask

  task automatic pulse_next();
    IF_next = 1'b1;
    @(negedge IF_clk);
    IF_next = 1'b0;
  endtask

  task automatic pulse_jump(input logic [7:0] a);
    IF_jump      = 1'b1;
    IF_jump_addr = a;
    @(negedge IF_clk);
    IF_jump = 1'b0;
  endtask

  task automatic pulse_halt();
    IF_halt = 1'b1;
    @(negedge IF_clk);
    IF_halt = 1'b0;
  endtask

  task automatic pulse_start();
    IF_start = 1'b1;
    @(negedge IF_clk);
    IF_start = 1'b0;
  endtask

  task automatic restart_from_idle();
    int n;
    push_exp(8'h00);
    pulse_start();
    wait_valid(n);
    model_pc = 8'h00;
    check("restart_pc", 32'(IF_pc), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int         n;
    int         op;
    logic [7:0] t;

    IF_rst_n = 1'b0;
    IF_start = 1'b0;
    IF_next = 1'b0;
    IF_jump = 1'b0;
    IF_jump_addr = 8'h00;
    IF_halt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    mem[3] = 8'h33;

    repeat (2) @(negedge IF_clk);
    check_reset_outputs("reset");
    IF_rst_n = 1'b1;
    @(negedge IF_clk);

    // Start, zero-wait fetch of 0xA5 from address 0
    fixed_wait = 0;
    push_exp(8'h00);
    pulse_start();
    check("t1_mem_req", 32'(IF_mem_req), 1);
    check("t1_mem_addr", 32'(IF_mem_addr), 0);
    check("t1_busy", 32'(IF_busy), 1);
    wait_valid(n);
    check("t1_start_to_valid", 32'(n + 1), 3);
    check("t1_ir_data", 32'(IF_ir_data), 32'h A5);
    check("t1_pc", 32'(IF_pc), 0);

    // Three sequential fetches, 3-cycle next-to-valid each
    for (int i = 1; i <= 3; i++) begin
      push_exp(8'(i));
      pulse_next();
      check("t2_ir_valid_drop", 32'(IF_ir_valid), 0);
      wait_valid(n);
      check("t2_next_to_valid", 32'(n + 1), 3);
    end
    check("t2_pc", 32'(IF_pc), 3);

    // Ack held off for 5 cycles
    fixed_wait = 5;
    push_exp(8'h04);
    pulse_next();
    wait_valid(n);
    check("t3_req_cycles", 32'(last_req_cycles), 6);
    check("t3_next_to_valid", 32'(n + 1), 8);
    check("t3_pc", 32'(IF_pc), 4);

    // Jump to 0x40 while the fetch of 0x05 is outstanding
    fixed_wait = 3;
    push_exp(8'h05);
    pulse_next();
    check("t4_mem_addr", 32'(IF_mem_addr), 5);
    drop_last();
    push_exp(8'h40);
    pulse_jump(8'h40);
    wait_valid(n);
    check("t4_pc", 32'(IF_pc), 32'h40);

    // PC wrap and jump-over-next priority
    fixed_wait = 0;
    push_exp(8'hFF);
    pulse_jump(8'hFF);
    wait_valid(n);
    check("t5_pc_ff", 32'(IF_pc), 32'hFF);
    push_exp(8'h00);
    pulse_next();
    check("t5_wrap_addr", 32'(IF_mem_addr), 0);
    wait_valid(n);
    check("t5_pc_wrapped", 32'(IF_pc), 0);
    push_exp(8'h10);
    IF_next = 1'b1;
    pulse_jump(8'h10);
    IF_next = 1'b0;
    wait_valid(n);
    check("t5_jump_wins", 32'(IF_pc), 32'h10);

    // Reset in the middle of a request
    fixed_wait = 4;
    push_exp(8'h11);
    pulse_next();
    check("t6_req_before_reset", 32'(IF_mem_req), 1);
    IF_rst_n = 1'b0;
    drop_last();
    #1;
    check_reset_outputs("t6_mid_req_reset");
    @(negedge IF_clk);
    IF_rst_n = 1'b1;
    @(negedge IF_clk);
    fixed_wait = 0;
    restart_from_idle();

    // Halt in READY
    pulse_halt();
    check("t6_halt_valid", 32'(IF_ir_valid), 0);
    check("t6_halt_busy", 32'(IF_busy), 0);
    repeat (3) @(negedge IF_clk);
    check("t6_idle_no_req", 32'(IF_mem_req), 0);
    check("t6_ir_kept", 32'(IF_ir_data), 32'h A5);
    restart_from_idle();

    // Randomised traffic against the PC model
    fixed_wait = -1;
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 11));
      if (op <= 4) begin
        t = model_pc + 8'd1;
        push_exp(t);
        pulse_next();
        wait_valid(n);
        model_pc = t;
      end else if (op <= 6) begin
        t = 8'($urandom);
        push_exp(t);
        pulse_jump(t);
        wait_valid(n);
        model_pc = t;
      end else if (op == 7) begin
        push_exp(model_pc + 8'd1);
        pulse_next();
        t = 8'($urandom);
        drop_last();
        push_exp(t);
        pulse_jump(t);
        wait_valid(n);
        model_pc = t;
      end else if (op == 8) begin
        push_exp(model_pc + 8'd1);
        pulse_next();
        wait_we();
        t = 8'($urandom);
        push_exp(t);
        pulse_jump(t);
        wait_valid(n);
        model_pc = t;
      end else if (op == 9) begin
        t = model_pc + 8'd1;
        push_exp(t);
        pulse_next();
        wait_we();
        pulse_next();
        check("load_next_valid", 32'(IF_ir_valid), 1);
        repeat (3) @(negedge IF_clk);
        check("load_next_ignored", 32'(IF_mem_req), 0);
        model_pc = t;
      end else if (op == 10) begin
        push_exp(model_pc + 8'd1);
        pulse_next();
        drop_last();
        pulse_halt();
        wait_idle();
        check("req_halt_valid", 32'(IF_ir_valid), 0);
        restart_from_idle();
      end else begin
        pulse_halt();
        check("ready_halt_busy", 32'(IF_busy), 0);
        restart_from_idle();
      end
      check("model_pc", 32'(IF_pc), 32'(model_pc));
    end

    repeat (5) @(negedge IF_clk);
    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
